// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion: one round key per handshake, rounds 1..10,
// with a registered round key and rcon stepped by xtime after each round.
module aes_key_expand_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         last,
  output logic         busy,
  output logic         state_dbg
);

  // Handshake: a round key transfers on a rising clk edge where key_valid and
  // key_ready are both high; while key_valid is high and key_ready is low, the
  // key, round_num and last hold stable. key_ready with key_valid low is ignored.

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state, state_nxt;
  logic [127:0] round_key_nxt;
  logic [3:0]   round_num_nxt;
  logic         key_valid_nxt;
  logic [7:0]   rcon, rcon_nxt;

  logic [127:0] exp_in, exp_out;
  logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, g, w4, w5, w6, w7;

  // rcon is 0x01 whenever the FSM sits in IDLE, so one expander serves both
  // the initial load from cipher_key and every later round.
  always_comb begin
    exp_in = (state == IDLE) ? cipher_key : round_key;
    w0     = exp_in[127:96];
    w1     = exp_in[95:64];
    w2     = exp_in[63:32];
    w3     = exp_in[31:0];
    rot_w  = {w3[23:0], w3[31:24]};
    sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    g      = sub_w ^ {rcon, 24'h0};
    w4     = w0 ^ g;
    w5     = w4 ^ w1;
    w6     = w5 ^ w2;
    w7     = w6 ^ w3;
    exp_out = {w4, w5, w6, w7};
  end

  always_comb begin
    state_nxt     = state;
    round_key_nxt = round_key;
    round_num_nxt = round_num;
    key_valid_nxt = key_valid;
    rcon_nxt      = rcon;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = GEN;
          round_key_nxt = exp_out;
          round_num_nxt = 4'd1;
          key_valid_nxt = 1'b1;
          rcon_nxt      = xtime(rcon);
        end
      end
      GEN: begin
        if (key_valid && key_ready) begin
          if (round_num == 4'd10) begin
            state_nxt     = IDLE;
            round_num_nxt = 4'd0;
            key_valid_nxt = 1'b0;
            rcon_nxt      = 8'h01;
          end else begin
            round_key_nxt = exp_out;
            round_num_nxt = round_num + 4'd1;
            rcon_nxt      = xtime(rcon);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= 128'h0;
      round_num <= 4'd0;
      key_valid <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      state     <= state_nxt;
      round_key <= round_key_nxt;
      round_num <= round_num_nxt;
      key_valid <= key_valid_nxt;
      rcon      <= rcon_nxt;
    end
  end

  assign busy      = (state == GEN);
  assign last      = key_valid & (round_num == 4'd10);
  assign state_dbg = (state == GEN);

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using the FIPS-197 key expansion
// vectors; inputs change and outputs are sampled on the falling clock edge.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         last;
  logic         busy;
  logic         state_dbg;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] fips_rk [1:10];

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .round_key  (round_key),
    .round_num  (round_num),
    .last       (last),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_key(input logic [127:0] k);
    start = 1'b1;
    cipher_key = k;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    key_ready = 1'b1;
    while (key_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    key_ready = 1'b0;
    check_val("drain_idle", {127'h0, key_valid}, 128'h0);
  endtask

  initial begin
    int hs;
    int cyc;

    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    cipher_key = 128'h0;

    // reset state
    do_reset();
    check_val("rst_valid", {127'h0, key_valid}, 128'h0);
    check_val("rst_busy",  {127'h0, busy}, 128'h0);
    check_val("rst_num",   {124'h0, round_num}, 128'h0);
    check_val("rst_key",   round_key, 128'h0);
    check_val("rst_last",  {127'h0, last}, 128'h0);

    // start together with rst is ignored
    rst = 1'b1;
    start = 1'b1;
    cipher_key = KEY_A;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    check_val("rst_start_valid", {127'h0, key_valid}, 128'h0);
    check_val("rst_start_busy",  {127'h0, busy}, 128'h0);

    // key_ready while idle has no effect
    key_ready = 1'b1;
    tick();
    tick();
    check_val("idle_ready_valid", {127'h0, key_valid}, 128'h0);
    check_val("idle_ready_num",   {124'h0, round_num}, 128'h0);

    // full run with key_ready held; cipher_key scrambled after start
    key_ready = 1'b1;
    start_key(KEY_A);
    cipher_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    for (int n = 1; n <= 10; n++) begin
      check_val($sformatf("run_key%0d", n), round_key, fips_rk[n]);
      check_val($sformatf("run_num%0d", n), {124'h0, round_num}, 128'(n));
      check_val($sformatf("run_last%0d", n), {127'h0, last}, {127'h0, (n == 10)});
      check_val($sformatf("run_valid%0d", n), {127'h0, key_valid}, 128'h1);
      tick();
    end
    check_val("end_valid", {127'h0, key_valid}, 128'h0);
    check_val("end_busy",  {127'h0, busy}, 128'h0);
    check_val("end_last",  {127'h0, last}, 128'h0);
    check_val("end_num",   {124'h0, round_num}, 128'h0);
    check_val("end_key",   round_key, fips_rk[10]);

    // back-pressure: hold key 1 for five cycles
    key_ready = 1'b0;
    start_key(KEY_A);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("hold_key%0d", i), round_key, fips_rk[1]);
      check_val($sformatf("hold_num%0d", i), {124'h0, round_num}, 128'h1);
      tick();
    end
    key_ready = 1'b1;
    tick();
    check_val("hold_key2", round_key, fips_rk[2]);
    check_val("hold_num2", {124'h0, round_num}, 128'h2);
    drain();

    // random back-pressure through the scoreboard
    for (int n = 1; n <= 10; n++) exp_q.push_back(fips_rk[n]);
    key_ready = 1'b0;
    start_key(KEY_A);
    hs = 0;
    cyc = 0;
    while (key_valid && cyc < 300) begin
      key_ready = 1'($urandom_range(0, 1));
      if (key_ready) begin
        if (exp_q.size() > 0) check_val("sb_key", round_key, exp_q.pop_front());
        check_val("sb_num", {124'h0, round_num}, 128'(hs + 1));
        hs++;
      end
      tick();
      cyc++;
    end
    key_ready = 1'b0;
    check_val("sb_handshakes", 128'(hs), 128'd10);
    check_val("sb_done", {127'h0, key_valid}, 128'h0);

    // start while busy (round 4 and the round-10 handshake) is ignored
    key_ready = 1'b1;
    start_key(KEY_A);
    for (int n = 1; n <= 10; n++) begin
      check_val($sformatf("busy_start_key%0d", n), round_key, fips_rk[n]);
      start = (n == 4 || n == 10);
      cipher_key = KEY_B;
      tick();
      start = 1'b0;
    end
    check_val("busy_start_idle", {127'h0, key_valid}, 128'h0);
    check_val("busy_start_nobusy", {127'h0, busy}, 128'h0);

    // reset mid-expansion at round 6, then restart with a new key
    key_ready = 1'b1;
    start_key(KEY_A);
    cyc = 0;
    while (round_num != 4'd6 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_val("abort_at6", round_key, fips_rk[6]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort_valid", {127'h0, key_valid}, 128'h0);
    check_val("abort_busy",  {127'h0, busy}, 128'h0);
    check_val("abort_key",   round_key, 128'h0);
    tick();
    check_val("abort_stays_idle", {127'h0, key_valid}, 128'h0);
    start_key(KEY_B);
    cyc = 0;
    while (round_num != 4'd10 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_val("keyb_r10", round_key, KEY_B10);
    check_val("keyb_last", {127'h0, last}, 128'h1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
